// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/done handshake: single-cycle logic/arith/shift ops,
// iterative shift-add multiply and restoring divide, registered results and flags.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] ans_hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_p0;
    logic [WIDTH-1:0] y_p0;
    logic [3:0]       sel_p0;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             res_c;
    logic             res_v;
    logic             res_z;

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    endfunction

    // x - y is formed as x + ~y + 1 so the carry out is the NOT-borrow flag
    assign add_w    = {1'b0, x_p0} + {1'b0, y_p0};
    assign sub_w    = {1'b0, x_p0} + {1'b0, ~y_p0} + {{WIDTH{1'b0}}, 1'b1};
    assign shl_w    = {1'b0, x_p0} << y_p0[SHW-1:0];
    assign shr_w    = {x_p0, 1'b0} >> y_p0[SHW-1:0];

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, x_p0} : '0);
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, y_p0});
    assign div_diff = div_sh[WIDTH-1:0] - y_p0;

    always_comb begin
        res    = '0;
        res_hi = '0;
        res_c  = 1'b0;
        res_v  = 1'b0;
        case (sel_p0)
            OP_ADD: begin
                res   = add_w[WIDTH-1:0];
                res_c = add_w[WIDTH];
                res_v = add_ovf(x_p0, y_p0, add_w[WIDTH-1:0]);
            end
            OP_SUB: begin
                res   = sub_w[WIDTH-1:0];
                res_c = sub_w[WIDTH];
                res_v = add_ovf(x_p0, ~y_p0, sub_w[WIDTH-1:0]);
            end
            OP_AND: res = x_p0 & y_p0;
            OP_OR:  res = x_p0 | y_p0;
            OP_XOR: res = x_p0 ^ y_p0;
            OP_NOT: res = ~x_p0;
            OP_SHL: begin
                res   = shl_w[WIDTH-1:0];
                res_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                res   = shr_w[WIDTH:1];
                res_c = shr_w[0];
            end
            OP_MUL: begin
                res    = acc_lo;
                res_hi = acc_hi;
                res_c  = (acc_hi != '0);
                res_v  = (acc_hi != '0);
            end
            OP_DIV: begin
                res    = acc_lo;
                res_hi = acc_hi;
                res_v  = (y_p0 == '0);
            end
            default: ;
        endcase
        res_z = (sel_p0 == OP_MUL) ? ({res_hi, res} == '0) : (res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ans      <= '0;
            ans_hi   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_p0   <= x;
                        y_p0   <= y;
                        sel_p0 <= select;
                        busy   <= 1'b1;
                        cnt    <= SHW'(WIDTH - 1);
                        acc_hi <= '0;
                        acc_lo <= (select == OP_MUL) ? y : x;
                        state  <= (select == OP_MUL || select == OP_DIV) ? ITER : EXEC;
                    end
                end
                EXEC: begin
                    ans      <= res;
                    ans_hi   <= res_hi;
                    zero     <= res_z;
                    carry    <= res_c;
                    negative <= res[WIDTH-1];
                    overflow <= res_v;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                // One quotient/product bit per cycle; the last iteration hands off to
                // EXEC so every op shares the same result/flag writeback.
                ITER: begin
                    if (sel_p0 == OP_MUL) begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (div_ge) begin
                        acc_hi <= div_diff;
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= EXEC;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
